// File: rtl/uart_rx_ctrl_if.sv
// Bundle between the serial synchronizer / config source and the UART receive controller.
// The slave modport is the receiver's view; master is the driving side.
interface uart_rx_ctrl_if #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
);
   logic                  S_DATA;
   logic [PRESCALE_W-1:0] prescale;
   logic                  parity_enable;
   logic                  parity_type;
   logic                  two_stop;
   logic [DATA_WIDTH-1:0] P_DATA;
   logic                  data_valid;
   logic                  par_err;
   logic                  stp_err;
   logic                  busy;
   logic                  break_det;

   modport slave (
      input  S_DATA, prescale, parity_enable, parity_type, two_stop,
      output P_DATA, data_valid, par_err, stp_err, busy, break_det
   );

   modport master (
      output S_DATA, prescale, parity_enable, parity_type, two_stop,
      input  P_DATA, data_valid, par_err, stp_err, busy, break_det
   );
endinterface

// File: rtl/uart_rx_ctrl.sv
// Oversampling UART receiver: 3-sample majority vote, LSB-first deserializer, parity/stop checks.
// Line-break detection is built only when UART_RX_BREAK_DET_EN is defined.
module uart_rx_ctrl #(
   parameter int unsigned DATA_WIDTH = 8,
   parameter int unsigned PRESCALE_W = 6
) (
   input logic           CLK,
   input logic           RST,
   uart_rx_ctrl_if.slave bus
);

`ifdef UART_RX_BREAK_DET_EN
   localparam bit BreakEn = 1'b1;
`else
   localparam bit BreakEn = 1'b0;
`endif

   localparam logic [3:0] LastBit = 4'(DATA_WIDTH - 1);

   typedef enum logic [2:0] {StIdle, StStart, StData, StParity, StStop, StDone} state_e;

   function automatic logic maj3(input logic [2:0] s);
      return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
   endfunction

   state_e                state_q, state_d;
   logic [PRESCALE_W-1:0] edge_q, edge_d;
   logic [PRESCALE_W-1:0] prescale_q, prescale_d;
   logic [3:0]            bit_q, bit_d;
   logic [2:0]            samp_q, samp_d;
   logic [DATA_WIDTH-1:0] shreg_q, shreg_d;
   logic [DATA_WIDTH-1:0] p_data_q, p_data_d;
   logic                  par_en_q, par_en_d, par_type_q, par_type_d, two_q, two_d;
   logic                  par_bad_q, par_bad_d, stp_bad_q, stp_bad_d, zero_q, zero_d;
   logic                  dv_q, dv_d, pe_q, pe_d, se_q, se_d, brk_q, brk_d, busy_q, busy_d;

   logic [PRESCALE_W-1:0] half, half_m1, half_p1, half_p2;
   logic                  last_edge, samp_edge, maj_q, maj_now, stp_fail, zero_fin;

   assign half      = prescale_q >> 1;
   assign half_m1   = half - PRESCALE_W'(1);
   assign half_p1   = half + PRESCALE_W'(1);
   assign half_p2   = half + PRESCALE_W'(2);
   assign last_edge = (edge_q == prescale_q - PRESCALE_W'(1));
   assign samp_edge = (edge_q == half_m1) || (edge_q == half) || (edge_q == half_p1);
   assign maj_q     = maj3(samp_q);
   // Stop decisions happen on the third sample's own cycle, so fold in the live line value.
   assign maj_now   = maj3({samp_q[1:0], bus.S_DATA});
   assign stp_fail  = stp_bad_q | ~maj_now;
   assign zero_fin  = zero_q & ~maj_now;

   always_comb begin
      state_d    = state_q;
      edge_d     = edge_q + PRESCALE_W'(1);
      bit_d      = bit_q;
      samp_d     = samp_edge ? {samp_q[1:0], bus.S_DATA} : samp_q;
      shreg_d    = shreg_q;
      prescale_d = prescale_q;
      par_en_d   = par_en_q;
      par_type_d = par_type_q;
      two_d      = two_q;
      par_bad_d  = par_bad_q;
      stp_bad_d  = stp_bad_q;
      zero_d     = zero_q;
      p_data_d   = p_data_q;
      dv_d       = 1'b0;
      pe_d       = 1'b0;
      se_d       = 1'b0;
      brk_d      = 1'b0;

      unique case (state_q)
         StIdle: begin
            edge_d = '0;
            if (!bus.S_DATA) begin
               prescale_d = bus.prescale;
               par_en_d   = bus.parity_enable;
               par_type_d = bus.parity_type;
               two_d      = bus.two_stop;
               edge_d     = PRESCALE_W'(1);
               bit_d      = '0;
               par_bad_d  = 1'b0;
               stp_bad_d  = 1'b0;
               zero_d     = 1'b1;
               state_d    = StStart;
            end
         end
         StStart: begin
            if (edge_q == half_p2 && maj_q) begin
               state_d = StIdle;
            end else if (last_edge) begin
               edge_d  = '0;
               bit_d   = '0;
               state_d = StData;
            end
         end
         StData: begin
            if (last_edge) begin
               edge_d  = '0;
               shreg_d = {maj_q, shreg_q[DATA_WIDTH-1:1]};
               if (maj_q) zero_d = 1'b0;
               if (bit_q == LastBit) begin
                  bit_d   = '0;
                  state_d = par_en_q ? StParity : StStop;
               end else begin
                  bit_d = bit_q + 4'd1;
               end
            end
         end
         StParity: begin
            if (last_edge) begin
               edge_d    = '0;
               par_bad_d = maj_q != (^shreg_q ^ par_type_q);
               if (maj_q) zero_d = 1'b0;
               state_d   = StStop;
            end
         end
         StStop: begin
            if (edge_q == half_p1) begin
               stp_bad_d = stp_fail;
               zero_d    = zero_fin;
               if (!two_q || bit_q == 4'd1) begin
                  edge_d  = '0;
                  state_d = StDone;
                  if (BreakEn && zero_fin) begin
                     brk_d = 1'b1;
                  end else begin
                     pe_d = par_bad_q;
                     se_d = stp_fail;
                     if (!par_bad_q && !stp_fail) begin
                        dv_d     = 1'b1;
                        p_data_d = shreg_q;
                     end
                  end
               end
            end else if (last_edge) begin
               edge_d = '0;
               bit_d  = 4'd1;
            end
         end
         StDone: begin
            state_d = StIdle;
            // After a break, hold off until the line has idled high for a full bit time.
            if (BreakEn && zero_q) begin
               edge_d = bus.S_DATA ? edge_q + PRESCALE_W'(1) : '0;
               if (!(bus.S_DATA && last_edge)) state_d = StDone;
            end
         end
         default: state_d = StIdle;
      endcase

      busy_d = (state_d != StIdle);
   end

   always_ff @(posedge CLK or negedge RST) begin
      if (!RST) begin
         state_q    <= StIdle;
         edge_q     <= '0;
         prescale_q <= '0;
         bit_q      <= '0;
         samp_q     <= '0;
         shreg_q    <= '0;
         p_data_q   <= '0;
         par_en_q   <= 1'b0;
         par_type_q <= 1'b0;
         two_q      <= 1'b0;
         par_bad_q  <= 1'b0;
         stp_bad_q  <= 1'b0;
         zero_q     <= 1'b0;
         dv_q       <= 1'b0;
         pe_q       <= 1'b0;
         se_q       <= 1'b0;
         brk_q      <= 1'b0;
         busy_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         edge_q     <= edge_d;
         prescale_q <= prescale_d;
         bit_q      <= bit_d;
         samp_q     <= samp_d;
         shreg_q    <= shreg_d;
         p_data_q   <= p_data_d;
         par_en_q   <= par_en_d;
         par_type_q <= par_type_d;
         two_q      <= two_d;
         par_bad_q  <= par_bad_d;
         stp_bad_q  <= stp_bad_d;
         zero_q     <= zero_d;
         dv_q       <= dv_d;
         pe_q       <= pe_d;
         se_q       <= se_d;
         brk_q      <= brk_d;
         busy_q     <= busy_d;
      end
   end

   assign bus.P_DATA     = p_data_q;
   assign bus.data_valid = dv_q;
   assign bus.par_err    = pe_q;
   assign bus.stp_err    = se_q;
   assign bus.busy       = busy_q;
   assign bus.break_det  = brk_q;

endmodule

// File: tb/tb_uart_rx_ctrl.sv
// Directed bench for uart_rx_ctrl: frame timing, parity/stop errors, glitches, back-to-back, break.
// Cycle numbers are relative to the first low cycle of the marked frame.
module tb_uart_rx_ctrl;
   localparam int unsigned DW = 8;
   localparam int unsigned PW = 6;

   logic CLK = 1'b0;
   logic RST = 1'b0;

   uart_rx_ctrl_if #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) u_if ();

   uart_rx_ctrl #(.DATA_WIDTH(DW), .PRESCALE_W(PW)) u_dut (
      .CLK (CLK),
      .RST (RST),
      .bus (u_if.slave)
   );

   always #5 CLK = ~CLK;

   int cyc = 0;
   always @(posedge CLK) cyc <= cyc + 1;

   int         n_chk = 0;
   int         n_fail = 0;
   int         t0 = 1 << 30;
   int         dv_n, pe_n, se_n, brk_n;
   int         dv_cyc [4];
   logic [7:0] dv_data [4];
   int         pe_cyc, se_cyc, brk_cyc;
   logic       busy_hist [512];

   // Outputs are sampled mid-cycle; index is the cycle relative to t0.
   always @(negedge CLK) begin
      int rel;
      rel = cyc - t0;
      if (rel >= 0 && rel < 512) busy_hist[rel] = u_if.busy;
      if (u_if.data_valid) begin
         if (dv_n < 4) begin
            dv_cyc[dv_n]  = rel;
            dv_data[dv_n] = u_if.P_DATA;
         end
         dv_n++;
      end
      if (u_if.par_err) begin
         if (pe_n == 0) pe_cyc = rel;
         pe_n++;
      end
      if (u_if.stp_err) begin
         if (se_n == 0) se_cyc = rel;
         se_n++;
      end
      if (u_if.break_det) begin
         if (brk_n == 0) brk_cyc = rel;
         brk_n++;
      end
   end

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic tick(input logic v);
      u_if.S_DATA = v;
      @(posedge CLK);
      #1;
   endtask

   task automatic clear_mon();
      dv_n = 0; pe_n = 0; se_n = 0; brk_n = 0;
      pe_cyc = -1; se_cyc = -1; brk_cyc = -1;
      for (int i = 0; i < 4; i++) begin
         dv_cyc[i]  = -1;
         dv_data[i] = '0;
      end
      for (int i = 0; i < 512; i++) busy_hist[i] = 1'bx;
      t0 = 1 << 30;
   endtask

   task automatic cfg(input int p, input bit pe, input bit pt, input bit ts);
      u_if.prescale      = PW'(p);
      u_if.parity_enable = pe;
      u_if.parity_type   = pt;
      u_if.two_stop      = ts;
   endtask

   task automatic send_frame(input logic [7:0] data, input int p, input bit par_en,
                             input bit par_bit, input int nstop, input logic [1:0] stops,
                             input bit mark);
      if (mark) t0 = cyc;
      repeat (p) tick(1'b0);
      for (int i = 0; i < DW; i++) repeat (p) tick(data[i]);
      if (par_en) repeat (p) tick(par_bit);
      for (int s = 0; s < nstop; s++) repeat (p) tick(stops[s]);
   endtask

   initial begin
      u_if.S_DATA = 1'b1;
      cfg(8, 1'b0, 1'b0, 1'b0);
      clear_mon();
      repeat (3) @(posedge CLK);
      #1;
      RST = 1'b1;
      tick(1'b1);
      tick(1'b1);

      check_eq("rst_p_data", 32'(u_if.P_DATA), 32'h0);
      check_eq("rst_data_valid", 32'(u_if.data_valid), 32'h0);
      check_eq("rst_par_err", 32'(u_if.par_err), 32'h0);
      check_eq("rst_stp_err", 32'(u_if.stp_err), 32'h0);
      check_eq("rst_busy", 32'(u_if.busy), 32'h0);
      check_eq("rst_break_det", 32'(u_if.break_det), 32'h0);

      // 8N1, P=8, 0xA5: S=9 -> pulse at 9*8+4+2 = 78
      clear_mon();
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      repeat (24) tick(1'b1);
      check_eq("t1_dv_count", 32'(dv_n), 32'd1);
      check_eq("t1_dv_cycle", 32'(dv_cyc[0]), 32'd78);
      check_eq("t1_dv_data", 32'(dv_data[0]), 32'hA5);
      check_eq("t1_p_data_held", 32'(u_if.P_DATA), 32'hA5);
      check_eq("t1_par_err_count", 32'(pe_n), 32'd0);
      check_eq("t1_stp_err_count", 32'(se_n), 32'd0);
      check_eq("t1_busy_c0", 32'(busy_hist[0]), 32'd0);
      check_eq("t1_busy_c1", 32'(busy_hist[1]), 32'd1);
      check_eq("t1_busy_c78", 32'(busy_hist[78]), 32'd1);
      check_eq("t1_busy_c79", 32'(busy_hist[79]), 32'd0);

      // 8E1, P=16, 0x07 has odd popcount so correct even parity is 1; send 0.
      // Stop is bit 10: pulse at 10*16+8+2 = 170
      cfg(16, 1'b1, 1'b0, 1'b0);
      clear_mon();
      send_frame(8'h07, 16, 1'b1, 1'b0, 1, 2'b11, 1'b1);
      repeat (48) tick(1'b1);
      check_eq("t2_par_err_count", 32'(pe_n), 32'd1);
      check_eq("t2_par_err_cycle", 32'(pe_cyc), 32'd170);
      check_eq("t2_stp_err_count", 32'(se_n), 32'd0);
      check_eq("t2_dv_count", 32'(dv_n), 32'd0);
      check_eq("t2_p_data_kept", 32'(u_if.P_DATA), 32'hA5);

      // 8N2, P=32, second stop 0: pulse at 10*32+16+2 = 338
      cfg(32, 1'b0, 1'b0, 1'b1);
      clear_mon();
      send_frame(8'h3C, 32, 1'b0, 1'b0, 2, 2'b01, 1'b1);
      repeat (96) tick(1'b1);
      check_eq("t3_stp_err_count", 32'(se_n), 32'd1);
      check_eq("t3_stp_err_cycle", 32'(se_cyc), 32'd338);
      check_eq("t3_dv_count", 32'(dv_n), 32'd0);
      check_eq("t3_par_err_count", 32'(pe_n), 32'd0);
      check_eq("t3_p_data_kept", 32'(u_if.P_DATA), 32'hA5);

      // Start glitch, 3 low cycles at P=8: busy high through cycle 6, low at 7
      cfg(8, 1'b0, 1'b0, 1'b0);
      clear_mon();
      t0 = cyc;
      repeat (3) tick(1'b0);
      repeat (12) tick(1'b1);
      check_eq("t4_busy_c1", 32'(busy_hist[1]), 32'd1);
      check_eq("t4_busy_c6", 32'(busy_hist[6]), 32'd1);
      check_eq("t4_busy_c7", 32'(busy_hist[7]), 32'd0);
      check_eq("t4_pulses", 32'(dv_n + pe_n + se_n + brk_n), 32'd0);
      clear_mon();
      send_frame(8'h5A, 8, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      repeat (24) tick(1'b1);
      check_eq("t4_dv_count", 32'(dv_n), 32'd1);
      check_eq("t4_dv_cycle", 32'(dv_cyc[0]), 32'd78);
      check_eq("t4_dv_data", 32'(dv_data[0]), 32'h5A);

      // Back-to-back 8N1 P=16, second start at 160: pulses at 154 and 314
      cfg(16, 1'b0, 1'b0, 1'b0);
      clear_mon();
      send_frame(8'h11, 16, 1'b0, 1'b0, 1, 2'b11, 1'b1);
      send_frame(8'hEE, 16, 1'b0, 1'b0, 1, 2'b11, 1'b0);
      repeat (48) tick(1'b1);
      check_eq("t5_dv_count", 32'(dv_n), 32'd2);
      check_eq("t5_dv0_cycle", 32'(dv_cyc[0]), 32'd154);
      check_eq("t5_dv0_data", 32'(dv_data[0]), 32'h11);
      check_eq("t5_dv1_cycle", 32'(dv_cyc[1]), 32'd314);
      check_eq("t5_dv1_data", 32'(dv_data[1]), 32'hEE);

      // Line held low for 12 bits at P=8, then high (returns at cycle 96)
      cfg(8, 1'b0, 1'b0, 1'b0);
      clear_mon();
      t0 = cyc;
      repeat (96) tick(1'b0);
      repeat (200) tick(1'b1);
`ifdef UART_RX_BREAK_DET_EN
      check_eq("t6_break_count", 32'(brk_n), 32'd1);
      check_eq("t6_break_cycle", 32'(brk_cyc), 32'd78);
      check_eq("t6_stp_err_count", 32'(se_n), 32'd0);
      check_eq("t6_dv_count", 32'(dv_n), 32'd0);
      check_eq("t6_busy_c103", 32'(busy_hist[103]), 32'd1);
      check_eq("t6_busy_c104", 32'(busy_hist[104]), 32'd0);
`else
      check_eq("t6_break_count", 32'(brk_n), 32'd0);
      check_eq("t6_stp_err_count", 32'(se_n), 32'd1);
      check_eq("t6_stp_err_cycle", 32'(se_cyc), 32'd78);
      check_eq("t6_par_err_count", 32'(pe_n), 32'd0);
`endif

      // Reset in the middle of a frame discards it and clears outputs
      clear_mon();
      t0 = cyc;
      repeat (8) tick(1'b0);
      repeat (20) tick(1'b1);
      check_eq("t7_busy_mid", 32'(u_if.busy), 32'd1);
      RST = 1'b0;
      #1;
      check_eq("t7_busy_rst", 32'(u_if.busy), 32'd0);
      check_eq("t7_p_data_rst", 32'(u_if.P_DATA), 32'h0);
      tick(1'b1);
      RST = 1'b1;
      repeat (100) tick(1'b1);
      check_eq("t7_dv_after", 32'(dv_n), 32'd0);
      check_eq("t7_busy_after", 32'(u_if.busy), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
